// File: rtl/fft_out_unloader.sv
// Ping-pong frame buffer between the last FFT stage and a serial consumer.
// Captures N complex samples in one cycle and streams them out in frequency order.
module fft_out_unloader #(
    parameter int unsigned W      = 16,
    parameter int unsigned N      = 32,
    parameter int unsigned LOG2N  = 5,
    parameter int unsigned BITREV = 1
) (
    input  logic               clk_MAC,
    input  logic               rst,
    input  logic               frame_valid,
    output logic               frame_ready,
    input  logic [N*W-1:0]     frame_r,
    input  logic [N*W-1:0]     frame_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_r,
    output logic [W-1:0]       out_i,
    output logic [LOG2N-1:0]   out_idx,
    output logic               out_last,
    output logic               frame_drop
);

    logic [W-1:0]     r_mem_r [2][N];
    logic [W-1:0]     r_mem_i [2][N];
    logic [1:0]       r_full;
    logic             r_wbank;
    logic             r_rbank;
    logic [LOG2N-1:0] r_idx;
    logic             r_drop;
    logic             r_rst_q;

    logic             w_capture;
    logic             w_beat;
    logic             w_wrap;
    logic [1:0]       w_full_nxt;
    logic [LOG2N-1:0] w_slot;

    function automatic logic [LOG2N-1:0] f_bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] res;
        for (int b = 0; b < LOG2N; b++) begin
            res[b] = v[LOG2N-1-b];
        end
        return res;
    endfunction

    assign frame_ready = !r_rst_q && !r_full[r_wbank];
    assign w_capture   = frame_valid && frame_ready && !rst;
    assign out_valid   = r_full[r_rbank];
    assign w_beat      = out_valid && out_ready;
    assign w_wrap      = w_beat && (r_idx == LOG2N'(N - 1));
    assign w_slot      = (BITREV != 0) ? f_bitrev(r_idx) : r_idx;
    assign frame_drop  = r_drop;

    // The freeing and the filling bank always differ, so both updates apply.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wrap) begin
            w_full_nxt[r_rbank] = 1'b0;
        end
        if (w_capture) begin
            w_full_nxt[r_wbank] = 1'b1;
        end
    end

    always_ff @(posedge clk_MAC) begin
        r_rst_q <= rst;
        if (rst) begin
            r_full  <= 2'b00;
            r_wbank <= 1'b0;
            r_rbank <= 1'b0;
            r_idx   <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_full <= w_full_nxt;
            r_drop <= frame_valid && !frame_ready;
            if (w_capture) begin
                r_wbank <= !r_wbank;
            end
            if (w_beat) begin
                r_idx <= w_wrap ? '0 : r_idx + 1'b1;
            end
            if (w_wrap) begin
                r_rbank <= !r_rbank;
            end
        end
    end

    // Bank contents survive reset; only the full flags gate visibility.
    always_ff @(posedge clk_MAC) begin
        if (w_capture) begin
            for (int j = 0; j < N; j++) begin
                r_mem_r[r_wbank][j] <= frame_r[j*W +: W];
                r_mem_i[r_wbank][j] <= frame_i[j*W +: W];
            end
        end
    end

    always_comb begin
        out_r    = '0;
        out_i    = '0;
        out_idx  = '0;
        out_last = 1'b0;
        if (out_valid) begin
            out_r    = r_mem_r[r_rbank][w_slot];
            out_i    = r_mem_i[r_rbank][w_slot];
            out_idx  = r_idx;
            out_last = (r_idx == LOG2N'(N - 1));
        end
    end

endmodule

// File: tb/tb_fft_out_unloader.sv
// Scoreboard bench for fft_out_unloader: stimulus pushes expected beats,
// a forked monitor pops and compares them at the falling edge.
module tb_fft_out_unloader;

    localparam int W = 16;
    localparam int N = 32;
    localparam int L = 5;

    typedef struct packed {
        logic [W-1:0] r;
        logic [W-1:0] i;
        logic [L-1:0] idx;
        logic         last;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           frame_valid;
    logic           frame_valid0;
    logic [N*W-1:0] frame_r;
    logic [N*W-1:0] frame_i;
    logic           out_ready;

    logic           frame_ready, out_valid, out_last, frame_drop;
    logic [W-1:0]   out_r, out_i;
    logic [L-1:0]   out_idx;
    logic           frame_ready0, out_valid0, out_last0, frame_drop0;
    logic [W-1:0]   out_r0, out_i0;
    logic [L-1:0]   out_idx0;

    beat_t q1[$];
    beat_t q0[$];
    int    errors = 0;
    int    checks = 0;
    int    ready_mode = 0;
    int    pat_cnt = 0;

    always #5 clk = ~clk;

    fft_out_unloader #(.W(W), .N(N), .LOG2N(L), .BITREV(1)) u_dut (
        .clk_MAC(clk), .rst(rst), .frame_valid(frame_valid), .frame_ready(frame_ready),
        .frame_r(frame_r), .frame_i(frame_i), .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_i(out_i), .out_idx(out_idx), .out_last(out_last),
        .frame_drop(frame_drop)
    );

    fft_out_unloader #(.W(W), .N(N), .LOG2N(L), .BITREV(0)) u_dut0 (
        .clk_MAC(clk), .rst(rst), .frame_valid(frame_valid0), .frame_ready(frame_ready0),
        .frame_r(frame_r), .frame_i(frame_i), .out_valid(out_valid0), .out_ready(out_ready),
        .out_r(out_r0), .out_i(out_i0), .out_idx(out_idx0), .out_last(out_last0),
        .frame_drop(frame_drop0)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (ready_mode == 2) begin
            pat_cnt++;
            out_ready = ((pat_cnt % 4) == 0) || ((pat_cnt % 4) == 3);
        end
    endtask

    // Slot j carries (base+j, -(base+j)); expected beats go to q1 (bitrev) or q0 (natural).
    task automatic load_frame(input int base, input bit nat, input bit push);
        logic [L-1:0] k5;
        logic [L-1:0] s5;
        beat_t        e;
        for (int j = 0; j < N; j++) begin
            frame_r[j*W +: W] = W'(base + j);
            frame_i[j*W +: W] = W'(-(base + j));
        end
        if (push) begin
            for (int k = 0; k < N; k++) begin
                k5 = L'(k);
                for (int b = 0; b < L; b++) s5[b] = k5[L-1-b];
                if (nat) s5 = k5;
                e.r    = W'(base + int'(s5));
                e.i    = W'(-(base + int'(s5)));
                e.idx  = k5;
                e.last = (k == N - 1);
                if (nat) q0.push_back(e);
                else     q1.push_back(e);
            end
        end
    endtask

    task automatic drain(input int exp_cycles, input int inject_at, input string name);
        int c = 0;
        while ((q1.size() != 0 || q0.size() != 0) && c < 400) begin
            frame_valid = 1'b0;
            if (c == inject_at) begin
                chk({name, "_ready_at_last"}, 64'(frame_ready), 64'd1);
                chk({name, "_last_at_inject"}, 64'(out_last), 64'd1);
                load_frame(1000, 1'b0, 1'b1);
                frame_valid = 1'b1;
            end
            tick();
            c++;
        end
        frame_valid = 1'b0;
        chk({name, "_drained"}, 64'(q1.size() + q0.size()), 64'd0);
        if (exp_cycles > 0) chk({name, "_cycles"}, 64'(c), 64'(exp_cycles));
    endtask

    task automatic monitor();
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out_valid) begin
                    if (q1.size() == 0) begin
                        chk("bitrev_unexpected_beat", 64'({out_r, out_i, out_idx, out_last}), 64'd0);
                    end else begin
                        e = q1[0];
                        chk("bitrev_beat", 64'({out_r, out_i, out_idx, out_last}), 64'(e));
                        if (out_ready) void'(q1.pop_front());
                    end
                end else begin
                    chk("bitrev_idle_zero", 64'({out_r, out_i, out_idx, out_last}), 64'd0);
                end
                if (out_valid0) begin
                    if (q0.size() == 0) begin
                        chk("natural_unexpected_beat", 64'({out_r0, out_i0, out_idx0, out_last0}),
                            64'd0);
                    end else begin
                        e = q0[0];
                        chk("natural_beat", 64'({out_r0, out_i0, out_idx0, out_last0}), 64'(e));
                        if (out_ready) void'(q0.pop_front());
                    end
                end
            end
        end
    endtask

    task automatic stimulus();
        // Reset
        frame_valid  = 1'b0;
        frame_valid0 = 1'b0;
        out_ready    = 1'b1;
        frame_r      = '0;
        frame_i      = '0;
        tick();
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_frame_ready_low", 64'(frame_ready), 64'd0);
        chk("rst_frame_drop", 64'(frame_drop), 64'd0);
        rst = 1'b0;
        tick();
        chk("rst_frame_ready_rise", 64'(frame_ready), 64'd1);

        // 1: bit-reversed stream, ready held high
        load_frame(0, 1'b0, 1'b1);
        chk("t1_valid_before_capture", 64'(out_valid), 64'd0);
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        chk("t1_valid_latency", 64'(out_valid), 64'd1);
        chk("t1_first_r", 64'(out_r), 64'd0);
        drain(32, -1, "t1");

        // 2: ready pattern 1,0,0,1
        load_frame(40, 1'b0, 1'b1);
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        pat_cnt    = 0;
        out_ready  = 1'b1;
        ready_mode = 2;
        drain(0, -1, "t2");
        ready_mode = 0;
        out_ready  = 1'b1;
        repeat (4) tick();

        // 3: three back-to-back frames, consumer stalled
        out_ready = 1'b0;
        load_frame(100, 1'b0, 1'b1);
        frame_valid = 1'b1;
        tick();
        load_frame(300, 1'b0, 1'b1);
        tick();
        chk("t3_ready_low_both_full", 64'(frame_ready), 64'd0);
        load_frame(500, 1'b0, 1'b0);
        tick();
        frame_valid = 1'b0;
        chk("t3_drop_pulse", 64'(frame_drop), 64'd1);
        tick();
        chk("t3_drop_single", 64'(frame_drop), 64'd0);
        chk("t3_ready_still_low", 64'(frame_ready), 64'd0);
        out_ready = 1'b1;
        drain(64, -1, "t3");

        // 4: reset mid-frame
        load_frame(50, 1'b0, 1'b1);
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        repeat (10) tick();
        chk("t4_idx_before_rst", 64'(out_idx), 64'd10);
        rst = 1'b1;
        q1.delete();
        tick();
        rst = 1'b0;
        chk("t4_valid_after_rst", 64'(out_valid), 64'd0);
        chk("t4_idx_after_rst", 64'(out_idx), 64'd0);
        chk("t4_ready_after_rst", 64'(frame_ready), 64'd0);
        tick();
        chk("t4_ready_recovers", 64'(frame_ready), 64'd1);
        load_frame(700, 1'b0, 1'b1);
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        drain(32, -1, "t4");

        // 5: natural-order build
        load_frame(0, 1'b1, 1'b1);
        frame_valid0 = 1'b1;
        tick();
        frame_valid0 = 1'b0;
        chk("t5_valid_latency", 64'(out_valid0), 64'd1);
        drain(32, -1, "t5");

        // 6: capture on the last beat of the other bank, then gapless streaming
        load_frame(200, 1'b0, 1'b1);
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        drain(64, 31, "t6");
        repeat (4) tick();
    endtask

    initial begin
        rst = 1'b1;
        fork
            monitor();
            stimulus();
        join_any
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
